// File: rtl/reg_file_param.sv
// reg_file_param: parametrised multi-port CPU register file.
//   Three combinational read ports (Rd, Rs, Rm) and two synchronous write
//   ports (Rd, Rs). Addresses at or above DEPTH read as 0 and are never written.
//   When Rd and Rs write the same register, Rs wins. BYPASS=1 forwards
//   same-cycle write data to the read ports. Clear_Req starts a sequential
//   clear of one register per cycle. Busy is high while the clear runs, and
//   write ports are ignored while it is high.
// Ports:
//   Clock, Reset_n               clock, synchronous active-low reset
//   Rd_Addr, Rs_Addr, Rm_Addr    read/write addresses (Rm is read-only)
//   Rd_Wen, Rs_Wen               write enables
//   Rd_Data, Rs_Data             write data
//   Clear_Req                    start bulk clear
//   Rd_Out, Rs_Out, Rm_Out       read data (combinational)
//   Busy                         registered clear-in-progress flag
module reg_file_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned BYPASS = 0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Rd_Addr,
    input  logic [ADDR_W-1:0] Rs_Addr,
    input  logic [ADDR_W-1:0] Rm_Addr,
    input  logic              Rd_Wen,
    input  logic              Rs_Wen,
    input  logic [DATA_W-1:0] Rd_Data,
    input  logic [DATA_W-1:0] Rs_Data,
    input  logic              Clear_Req,
    output logic [DATA_W-1:0] Rd_Out,
    output logic [DATA_W-1:0] Rs_Out,
    output logic [DATA_W-1:0] Rm_Out,
    output logic              Busy
);

    localparam int unsigned     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               busy_q, busy_d;
    logic               clr_we;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               rd_in, rs_in;
    logic               rd_we, rs_we;
    logic [PTR_W-1:0]   rd_idx, rs_idx;

    // Write acceptance: enabled, in range, not clearing, not in reset
    always_comb begin
        rd_in  = {1'b0, Rd_Addr} < DEPTH_EXT;
        rs_in  = {1'b0, Rs_Addr} < DEPTH_EXT;
        rd_we  = Rd_Wen && rd_in && (state_q == S_IDLE) && Reset_n;
        rs_we  = Rs_Wen && rs_in && (state_q == S_IDLE) && Reset_n;
        rd_idx = PTR_W'(Rd_Addr);
        rs_idx = PTR_W'(Rs_Addr);
    end

    // Clear engine state register
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Clear engine next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_we  = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Clear_Req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = S_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == S_CLEAR);
    end

    // Register array; Rs beats Rd on a shared address
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_we && (ptr_q == PTR_W'(i))) begin
                    mem_q[i] <= '0;
                end else if (rs_we && (rs_idx == PTR_W'(i))) begin
                    mem_q[i] <= Rs_Data;
                end else if (rd_we && (rd_idx == PTR_W'(i))) begin
                    mem_q[i] <= Rd_Data;
                end
            end
        end
    end

    // One read port: range check, then optional same-cycle forwarding
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic              in_rng;
        logic [DATA_W-1:0] val;
        in_rng = {1'b0, addr} < DEPTH_EXT;
        val    = in_rng ? mem_q[PTR_W'(addr)] : '0;
        if ((BYPASS != 0) && in_rng) begin
            if (rd_we && (Rd_Addr == addr)) val = Rd_Data;
            if (rs_we && (Rs_Addr == addr)) val = Rs_Data;
        end
        return val;
    endfunction

    always_comb begin
        Rd_Out = read_port(Rd_Addr);
        Rs_Out = read_port(Rs_Addr);
        Rm_Out = read_port(Rm_Addr);
    end

    assign Busy = busy_q;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: one BYPASS=0 and one BYPASS=1 instance
// share all inputs so forwarding can be compared against the plain read path.
module tb_reg_file_param;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] rd_addr, rs_addr, rm_addr;
    logic              rd_wen, rs_wen;
    logic [DATA_W-1:0] rd_data, rs_data;
    logic              clear_req;
    logic [DATA_W-1:0] rd_out, rs_out, rm_out;
    logic [DATA_W-1:0] b_rd_out, b_rs_out, b_rm_out;
    logic              busy, b_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt;

    reg_file_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(0)) dut (
        .Clock(clk), .Reset_n(rst_n),
        .Rd_Addr(rd_addr), .Rs_Addr(rs_addr), .Rm_Addr(rm_addr),
        .Rd_Wen(rd_wen), .Rs_Wen(rs_wen), .Rd_Data(rd_data), .Rs_Data(rs_data),
        .Clear_Req(clear_req),
        .Rd_Out(rd_out), .Rs_Out(rs_out), .Rm_Out(rm_out), .Busy(busy)
    );

    reg_file_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BYPASS(1)) dut_byp (
        .Clock(clk), .Reset_n(rst_n),
        .Rd_Addr(rd_addr), .Rs_Addr(rs_addr), .Rm_Addr(rm_addr),
        .Rd_Wen(rd_wen), .Rs_Wen(rs_wen), .Rd_Data(rd_data), .Rs_Data(rs_data),
        .Clear_Req(clear_req),
        .Rd_Out(b_rd_out), .Rs_Out(b_rs_out), .Rm_Out(b_rm_out), .Busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one edge; sample 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rd_wen    = 1'b0;
        rs_wen    = 1'b0;
        clear_req = 1'b0;
    endtask

    // Read every register through Rm on both instances
    task automatic check_all(input string tag, input logic [DATA_W-1:0] exp);
        for (int a = 0; a < 16; a++) begin
            rm_addr = 7'(a);
            #1;
            check_eq($sformatf("%s_r%0d", tag, a), 32'(rm_out), 32'(exp));
            check_eq($sformatf("%s_byp_r%0d", tag, a), 32'(b_rm_out), 32'(exp));
        end
    endtask

    task automatic fill_all(input logic [DATA_W-1:0] val);
        for (int a = 0; a < 16; a++) begin
            rd_addr = 7'(a);
            rd_data = val;
            rd_wen  = 1'b1;
            tick();
        end
        rd_wen = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_addr = '0; rs_addr = '0; rm_addr = '0;
        rd_data = '0; rs_data = '0;
        idle_inputs();
        rst_n = 1'b0;
        #2;

        // 1. Reset: everything reads 0, Busy low
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr = 7'(a); rs_addr = 7'(a); rm_addr = 7'(a);
            #1;
            check_eq($sformatf("rst_rd%0d", a), 32'(rd_out), 32'h0);
            check_eq($sformatf("rst_rs%0d", a), 32'(rs_out), 32'h0);
            check_eq($sformatf("rst_rm%0d", a), 32'(rm_out), 32'h0);
        end
        check_eq("rst_busy", 32'(busy), 32'h0);

        // 2. Two distinct writes in one cycle; no forwarding without BYPASS
        rd_addr = 7'd3; rd_data = 16'hBEEF; rd_wen = 1'b1;
        rs_addr = 7'd5; rs_data = 16'h1234; rs_wen = 1'b1;
        rm_addr = 7'd3;
        #1;
        check_eq("pre_edge_nobyp", 32'(rm_out), 32'h0);
        tick();
        idle_inputs();
        rm_addr = 7'd3; #1;
        check_eq("wr_rd_a3", 32'(rm_out), 32'hBEEF);
        rm_addr = 7'd5; #1;
        check_eq("wr_rs_a5", 32'(rm_out), 32'h1234);

        // 3. Collision: Rs wins
        rd_addr = 7'd7; rd_data = 16'hAAAA; rd_wen = 1'b1;
        rs_addr = 7'd7; rs_data = 16'h5555; rs_wen = 1'b1;
        tick();
        idle_inputs();
        rm_addr = 7'd7; #1;
        check_eq("collide_a7", 32'(rm_out), 32'h5555);

        // 4. Out-of-range write lost, read returns 0
        rd_addr = 7'd20; rd_data = 16'hFFFF; rd_wen = 1'b1;
        tick();
        idle_inputs();
        for (int a = 0; a < 16; a++) begin
            rm_addr = 7'(a);
            #1;
            check_eq($sformatf("oor_keep%0d", a), 32'(rm_out),
                     (a == 3) ? 32'hBEEF : (a == 5) ? 32'h1234 : (a == 7) ? 32'h5555 : 32'h0);
        end
        rd_addr = 7'd20; #1;
        check_eq("oor_rd20", 32'(rd_out), 32'h0);
        rd_addr = 7'd127; #1;
        check_eq("oor_rd127", 32'(rd_out), 32'h0);

        // 5. Forwarding: Rs to addr 9 seen same cycle only with BYPASS
        rs_addr = 7'd9; rs_data = 16'h00C3; rs_wen = 1'b1;
        rm_addr = 7'd9;
        #1;
        check_eq("byp_rm9", 32'(b_rm_out), 32'h00C3);
        check_eq("nobyp_rm9", 32'(rm_out), 32'h0);
        rd_addr = 7'd9; rd_data = 16'hAAAA; rd_wen = 1'b1;
        #1;
        check_eq("byp_both_rd9", 32'(b_rd_out), 32'h00C3);
        rd_addr = 7'd4; rd_data = 16'h0404;
        #1;
        check_eq("byp_rd_port4", 32'(b_rd_out), 32'h0404);
        check_eq("nobyp_rd_port4", 32'(rd_out), 32'h0);
        tick();
        idle_inputs();
        rm_addr = 7'd9; #1;
        check_eq("post_byp_a9", 32'(rm_out), 32'h00C3);
        rs_addr = 7'd20; rs_data = 16'h7E7E; rs_wen = 1'b1;
        rm_addr = 7'd20;
        #1;
        check_eq("byp_oor_rm20", 32'(b_rm_out), 32'h0);
        tick();
        idle_inputs();

        // 6a. Full clear: Busy exactly DEPTH cycles, writes during Busy lost
        fill_all(16'h1111);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            if (cnt == 1) begin
                rd_addr = 7'd2; rd_data = 16'h2222; rd_wen = 1'b1;
                rm_addr = 7'd2;
                #1;
                check_eq("busy_no_byp", 32'(b_rm_out), 32'h1111);
            end
            if (cnt == 3) clear_req = 1'b1;
            tick();
            rd_wen    = 1'b0;
            clear_req = 1'b0;
        end
        check_eq("busy_cycles", 32'(cnt), 32'd16);
        check_eq("busy_low_after", 32'(busy), 32'h0);
        tick();
        check_eq("clear_req_ignored", 32'(busy), 32'h0);
        check_all("clr", 16'h0);

        // 6b. Write alongside Clear_Req lands; reset on 5th Busy cycle
        fill_all(16'h1111);
        clear_req = 1'b1;
        rd_addr = 7'd15; rd_data = 16'h7777; rd_wen = 1'b1;
        tick();
        idle_inputs();
        check_eq("busy_rise", 32'(busy), 32'h1);
        rm_addr = 7'd15; #1;
        check_eq("wr_with_clear", 32'(rm_out), 32'h7777);
        cnt = 1;
        while (cnt < 5) begin
            tick();
            cnt++;
        end
        check_eq("busy_5th", 32'(busy), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_eq("rst_mid_busy", 32'(busy), 32'h0);
        check_all("rstclr", 16'h0);

        // Back in IDLE: writes work again
        rd_addr = 7'd1; rd_data = 16'h4242; rd_wen = 1'b1;
        tick();
        idle_inputs();
        rm_addr = 7'd1; #1;
        check_eq("post_rst_wr", 32'(rm_out), 32'h4242);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
